rmu_sb: RTL and testbench

Parametrised register management unit with scoreboard. It is the next-generation GPR front end between decode/issue and the writeback units (ALU, LSU, CSR).
- Holds the integer register file.
- Arbitrates N writeback channels with a ready/valid handshake, one commit per cycle.
- Bypasses the committing value to M read ports.
- Tracks pending destinations in a busy scoreboard so issue can stall on RAW and WAW hazards.

---
 rtl/rmu_pkg.sv | 17 +
 rtl/rmu_sb_if.sv | 33 +++
 rtl/rmu_wb_arb.sv | 33 +++
 rtl/rmu_sb.sv | 71 +++++++
 tb/tb_rmu_sb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rmu_pkg.sv
// Shared defaults, writeback channel indices and the channel request bundle
// for the register management unit.
package rmu_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

  typedef struct packed {
    logic                vld;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rmu_sb_if.sv
// Bus between issue/writeback clients (master) and the register unit (slave).
interface rmu_sb_if
  import rmu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NWB  = 3,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_vld;
  logic [AW-1:0]       iss_rd;
  logic                iss_rdy;
  logic                flush;
  logic [NWB-1:0]      wb_vld;
  logic [NWB*AW-1:0]   wb_addr;
  logic [NWB*XLEN-1:0] wb_data;
  logic [NWB-1:0]      wb_rdy;

  modport master (
    output rd_addr, iss_vld, iss_rd, flush, wb_vld, wb_addr, wb_data,
    input  rd_data, rd_busy, iss_rdy, wb_rdy
  );

  modport slave (
    input  rd_addr, iss_vld, iss_rd, flush, wb_vld, wb_addr, wb_data,
    output rd_data, rd_busy, iss_rdy, wb_rdy
  );
endinterface

// File: rtl/rmu_wb_arb.sv
// Fixed-priority writeback arbiter: the lowest-index valid channel wins and
// its address/data are muxed onto the grant bus.
module rmu_wb_arb #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NWB  = 3
) (
  input  logic                en,
  input  logic [NWB-1:0]      wb_vld,
  input  logic [NWB*AW-1:0]   wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  output logic [NWB-1:0]      wb_rdy,
  output logic                g_vld,
  output logic [AW-1:0]       g_addr,
  output logic [XLEN-1:0]     g_data
);
  // Scan from the highest index down so the lowest valid index is the last writer.
  always_comb begin
    wb_rdy = '0;
    g_vld  = 1'b0;
    g_addr = '0;
    g_data = '0;
    for (int i = NWB - 1; i >= 0; i--) begin
      if (wb_vld[i]) begin
        wb_rdy    = '0;
        wb_rdy[i] = en;
        g_vld     = en;
        g_addr    = wb_addr[i*AW +: AW];
        g_data    = wb_data[i*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: rtl/rmu_sb.sv
// GPR file with prioritised writeback, same-cycle read bypass and a busy
// scoreboard for RAW/WAW stalls at issue.
module rmu_sb
  import rmu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NWB  = 3,
  parameter int NRD  = 2
) (
  input logic     clk,
  input logic     rst_n,
  rmu_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic            g_vld;
  logic [AW-1:0]   g_addr;
  logic [XLEN-1:0] g_data;
  logic            clr, set;

  rmu_wb_arb #(.XLEN(XLEN), .AW(AW), .NWB(NWB)) u_arb (
    .en      (rst_n),
    .wb_vld  (bus.wb_vld),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .wb_rdy  (bus.wb_rdy),
    .g_vld   (g_vld),
    .g_addr  (g_addr),
    .g_data  (g_data)
  );

  assign clr = g_vld && (g_addr != '0);
  assign set = bus.iss_vld && bus.iss_rdy && (bus.iss_rd != '0);

  // A retiring write to the claimed register frees it in the same cycle.
  assign bus.iss_rdy = rst_n && !bus.flush &&
                       (!busy_q[bus.iss_rd] || (clr && (g_addr == bus.iss_rd)));

  always_comb begin
    busy_d = bus.flush ? '0 : busy_q;
    if (clr) busy_d[g_addr] = 1'b0;
    if (set) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (clr) regs_q[g_addr] <= g_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = bus.rd_addr[gi*AW +: AW];
      assign hit  = clr && (g_addr == addr);
      assign bus.rd_data[gi*XLEN +: XLEN] = (addr == '0) ? '0 :
                                            hit ? g_data : regs_q[addr];
      assign bus.rd_busy[gi] = busy_q[addr] && !hit;
    end
  endgenerate
endmodule

// File: tb/tb_rmu_sb.sv
// Directed bench for rmu_sb: hand-computed reads, grants, stalls and flush.
module tb_rmu_sb;
  import rmu_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NWB  = 3;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  wb_req_t ch [NWB];

  rmu_sb_if #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB), .NRD(NRD)) bus ();

  rmu_sb #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive_wb();
    for (int i = 0; i < NWB; i++) begin
      bus.wb_vld[i]                 = ch[i].vld;
      bus.wb_addr[i*AW +: AW]       = ch[i].addr;
      bus.wb_data[i*XLEN +: XLEN]   = ch[i].data;
    end
    #1;
  endtask

  task automatic wb_set(input int i, input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    ch[i].vld  = v;
    ch[i].addr = a;
    ch[i].data = d;
    drive_wb();
  endtask

  task automatic wb_clear();
    for (int i = 0; i < NWB; i++) ch[i] = '0;
    drive_wb();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int j, input logic [AW-1:0] a);
    bus.rd_addr[j*AW +: AW] = a;
    #1;
  endtask

  function automatic logic [63:0] rdat(input int j);
    return bus.rd_data[j*XLEN +: XLEN];
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.rd_addr = '0;
    bus.iss_vld = 1'b0;
    bus.iss_rd  = '0;
    bus.flush   = 1'b0;
    wb_clear();

    // Held in reset: no grant, no claim
    wb_set(WB_ALU, 1'b1, 5'd9, 64'd7);
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd9; #1;
    check("rst_wb_rdy", 64'(bus.wb_rdy), 64'd0);
    check("rst_iss_rdy", 64'(bus.iss_rdy), 64'd0);
    step(); step();
    bus.iss_vld = 1'b0;
    wb_clear();
    rst_n = 1'b1;
    step();

    // 1: post-reset state
    set_rd(0, 5'd5);
    check("t1_rd_data", rdat(0), 64'd0);
    check("t1_rd_busy", 64'(bus.rd_busy[0]), 64'd0);
    check("t1_busy9_cleared", 64'(dut.busy_q[9]), 64'd0);
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd5; #1;
    check("t1_iss_rdy", 64'(bus.iss_rdy), 64'd1);
    step();

    // 2: x5 claimed, then retired by the LSU channel
    check("t2_rd_busy", 64'(bus.rd_busy[0]), 64'd1);
    check("t2_reissue_rdy", 64'(bus.iss_rdy), 64'd0);
    bus.iss_vld = 1'b0; #1;
    wb_set(WB_LSU, 1'b1, 5'd5, 64'hDEAD);
    check("t2_wb_rdy", 64'(bus.wb_rdy), 64'b010);
    check("t2_bypass", rdat(0), 64'hDEAD);
    check("t2_bypass_busy", 64'(bus.rd_busy[0]), 64'd0);
    check("t2_iss_rdy_clr", 64'(bus.iss_rdy), 64'd1);
    step();
    wb_clear();
    check("t2_busy_after", 64'(bus.rd_busy[0]), 64'd0);
    check("t2_reg_after", rdat(0), 64'hDEAD);

    // 3: three simultaneous writers served in priority order
    wb_set(WB_ALU, 1'b1, 5'd3, 64'd1);
    wb_set(WB_LSU, 1'b1, 5'd4, 64'd2);
    wb_set(WB_CSR, 1'b1, 5'd6, 64'd3);
    check("t3_grant0", 64'(bus.wb_rdy), 64'b001);
    step();
    wb_set(WB_ALU, 1'b0, 5'd0, 64'd0);
    check("t3_grant1", 64'(bus.wb_rdy), 64'b010);
    step();
    wb_set(WB_LSU, 1'b0, 5'd0, 64'd0);
    check("t3_grant2", 64'(bus.wb_rdy), 64'b100);
    step();
    wb_clear();
    set_rd(0, 5'd3); set_rd(1, 5'd4);
    check("t3_x3", rdat(0), 64'd1);
    check("t3_x4", rdat(1), 64'd2);
    set_rd(0, 5'd6);
    check("t3_x6", rdat(0), 64'd3);

    // 4: register 0 ignores writes and claims
    wb_set(WB_ALU, 1'b1, 5'd0, 64'hFFFF);
    set_rd(0, 5'd0);
    check("t4_wb_rdy", 64'(bus.wb_rdy), 64'b001);
    check("t4_x0_read", rdat(0), 64'd0);
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd0; #1;
    check("t4_iss_rdy", 64'(bus.iss_rdy), 64'd1);
    step();
    wb_clear();
    bus.iss_vld = 1'b0; #1;
    check("t4_x0_after", rdat(0), 64'd0);
    check("t4_x0_busy", 64'(bus.rd_busy[0]), 64'd0);

    // 5: new claim on x7 in the same cycle its old producer retires
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd7; #1;
    step();
    wb_set(WB_ALU, 1'b1, 5'd7, 64'd9);
    check("t5_iss_rdy", 64'(bus.iss_rdy), 64'd1);
    step();
    bus.iss_vld = 1'b0;
    wb_clear();
    set_rd(0, 5'd7);
    check("t5_x7", rdat(0), 64'd9);
    check("t5_x7_busy", 64'(bus.rd_busy[0]), 64'd1);

    // 6: flush with a concurrent writeback
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd1; #1;
    step();
    bus.iss_rd = 5'd2; #1;
    step();
    bus.iss_vld = 1'b0; #1;
    set_rd(0, 5'd1); set_rd(1, 5'd2);
    check("t6_x1_busy", 64'(bus.rd_busy[0]), 64'd1);
    check("t6_x2_busy", 64'(bus.rd_busy[1]), 64'd1);
    bus.flush = 1'b1;
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd9; #1;
    wb_set(WB_CSR, 1'b1, 5'd1, 64'd4);
    check("t6_flush_iss_rdy", 64'(bus.iss_rdy), 64'd0);
    check("t6_flush_wb_rdy", 64'(bus.wb_rdy), 64'b100);
    step();
    bus.flush = 1'b0;
    bus.iss_vld = 1'b0;
    wb_clear();
    check("t6_x1_clear", 64'(bus.rd_busy[0]), 64'd0);
    check("t6_x2_clear", 64'(bus.rd_busy[1]), 64'd0);
    check("t6_x1_data", rdat(0), 64'd4);
    bus.iss_rd = 5'd7; #1;
    check("t6_x7_free", 64'(bus.iss_rdy), 64'd1);
    check("t6_x9_not_set", 64'(dut.busy_q[9]), 64'd0);

    // Reset in the middle of a write drops it and clears the file
    wb_set(WB_ALU, 1'b1, 5'd8, 64'd5);
    rst_n = 1'b0; #1;
    check("t6_rst_wb_rdy", 64'(bus.wb_rdy), 64'd0);
    step();
    rst_n = 1'b1;
    wb_clear();
    set_rd(0, 5'd8); set_rd(1, 5'd5);
    check("t6_x8_dropped", rdat(0), 64'd0);
    check("t6_x5_reset", rdat(1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
